sa_output_drain: RTL and testbench

- Reader counterpart to the systolic controller's output-memory write path.
- After a multiply completes, it reads a programmable range of output-activation words from the output memory. It returns them to the host as a valid/ready stream with last-beat marking.
- Sits between the output memory read port and the host/DMA interface.
- Uses credit-based prefetch into a small FIFO, so it absorbs memory read latency and host backpressure without combinational ready-to-memory paths.

---
 rtl/sa_output_drain_if.sv | 12 +
 rtl/sa_output_drain.sv | 143 ++++++++++++++
 tb/tb_sa_output_drain.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_output_drain_if.sv
// Valid/ready output stream carrying drained output-activation words to the host.
interface sa_output_drain_if #(
    parameter int unsigned OUTPUT_WIDTH = 32
);
    logic [OUTPUT_WIDTH-1:0] o_data;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_last;

    modport master (output o_data, output o_valid, output o_last, input i_ready);
    modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/sa_output_drain.sv
// Reads a programmable range of output-memory words and streams them to the host,
// prefetching into a small credit-managed FIFO to hide read latency and backpressure.
module sa_output_drain #(
    parameter int unsigned OUTPUT_WIDTH  = 32,
    parameter int unsigned OUTPUT_HEIGHT = 16,
    parameter int unsigned FIFO_DEPTH    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [$clog2(OUTPUT_HEIGHT)-1:0] i_base_addr,
    input  logic [$clog2(OUTPUT_HEIGHT):0]   i_len,
    output logic                             r_output_cenb,
    output logic                             r_output_wenb,
    output logic [$clog2(OUTPUT_HEIGHT)-1:0] r_output_addr,
    input  logic [OUTPUT_WIDTH-1:0]          r_output_data,
    output logic                             o_busy,
    output logic                             o_done,
    sa_output_drain_if.master                strm
);
    localparam int unsigned AW = $clog2(OUTPUT_HEIGHT);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LW-1:0]     remain_q, remain_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     beat_q, beat_d;
    logic              inflight_q;
    logic              done_q, done_d;

    logic [OUTPUT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW:0]       used;
    logic              issue, push, pop, fifo_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check uses registered occupancy only, so ready never reaches the memory port.
    assign used       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue      = (state_q == StIssue) && (32'(used) < FIFO_DEPTH);
    assign push       = inflight_q;
    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && strm.i_ready;

    assign r_output_cenb = ~issue;
    assign r_output_wenb = 1'b1;
    assign r_output_addr = addr_q;

    assign strm.o_valid = fifo_valid;
    assign strm.o_data  = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
    assign strm.o_last  = fifo_valid && (beat_q == (len_q - LW'(1)));
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        len_d    = len_q;
        beat_d   = pop ? beat_q + LW'(1) : beat_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        addr_d   = i_base_addr;
                        remain_d = i_len;
                        len_d    = i_len;
                        beat_d   = '0;
                        state_d  = StIssue;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d   = (addr_q == AW'(OUTPUT_HEIGHT - 1)) ? '0 : addr_q + AW'(1);
                    remain_d = remain_q - LW'(1);
                    if (remain_q == LW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!fifo_valid && !inflight_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            inflight_q <= issue;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; o_data is gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= r_output_data;
    end
endmodule

// File: tb/tb_sa_output_drain.sv
// Directed bench for sa_output_drain: memory model, stream monitor and scenario tasks.
module tb_sa_output_drain;
    localparam int unsigned W = 32;
    localparam int unsigned H = 16;
    localparam int unsigned D = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  i_base_addr = '0;
    logic [4:0]  i_len = '0;
    logic        cenb, wenb, busy, done;
    logic [3:0]  addr;
    logic [31:0] rdata;

    sa_output_drain_if #(.OUTPUT_WIDTH(W)) strm ();

    sa_output_drain #(
        .OUTPUT_WIDTH (W),
        .OUTPUT_HEIGHT(H),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_len        (i_len),
        .r_output_cenb(cenb),
        .r_output_wenb(wenb),
        .r_output_addr(addr),
        .r_output_data(rdata),
        .o_busy       (busy),
        .o_done       (done),
        .strm         (strm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [H];
    initial for (int i = 0; i < H; i++) mem[i] = 32'h100 + i;
    always @(posedge clk) if (!cenb) rdata <= mem[addr];

    int checks = 0;
    int errors = 0;
    int rd_n, bn, valid_n, done_n;
    logic [3:0]  rd_addr [64];
    int          rd_cyc  [64];
    logic [31:0] b_data  [64];
    logic        b_last  [64];
    int          b_cyc   [64];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    // Observes at negedge; inputs only change #1 after posedge, so values are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(strm.o_valid && strm.o_data === prev_data && strm.o_last === prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             strm.o_valid, strm.o_data, strm.o_last, prev_data, prev_last);
                end
            end
            checks++;
            if (rd_n - bn > D) begin
                errors++;
                $display("FAIL outstanding got %0d want <= %0d", rd_n - bn, D);
            end
            if (!cenb && rd_n < 64) begin
                rd_addr[rd_n] = addr;
                rd_cyc[rd_n]  = cyc;
                rd_n++;
            end
            if (strm.o_valid) valid_n++;
            if (strm.o_valid && strm.i_ready && bn < 64) begin
                b_data[bn] = strm.o_data;
                b_last[bn] = strm.o_last;
                b_cyc[bn]  = cyc;
                bn++;
            end
            if (done) done_n++;
            prev_stall = strm.o_valid && !strm.i_ready;
            prev_data  = strm.o_data;
            prev_last  = strm.o_last;
        end
    end

    task automatic reset_logs();
        rd_n = 0; bn = 0; valid_n = 0; done_n = 0;
        for (int i = 0; i < 64; i++) begin
            b_data[i] = 'x; b_last[i] = 1'bx; rd_addr[i] = 'x;
        end
    endtask

    task automatic do_start(input logic [3:0] b, input logic [4:0] l, output int c0);
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = b; i_len = l;
        @(posedge clk); #1;
        i_start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int bound, input string name, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s_done_timeout got none want pulse within %0d cycles", name, bound);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [41:0] obs;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {cenb, wenb, addr, strm.o_valid, strm.o_last, busy, done, strm.o_data};
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs,
                     {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_logs();
    endtask

    task automatic test_full_depth();
        int c0, at;
        reset_logs();
        strm.i_ready = 1'b1;
        do_start(4'd0, 5'd16, c0);
        wait_done(30, "full", at);
        checks++;
        if (bn != 16 || rd_n != 16 || done_n != 1) begin
            errors++;
            $display("FAIL full_counts got beats=%0d reads=%0d done=%0d want 16/16/1", bn, rd_n, done_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (b_data[i] !== 32'h100 + i || b_last[i] !== (i == 15) || b_cyc[i] != b_cyc[0] + i) begin
                errors++;
                $display("FAIL full_beat[%0d] got %h/%b@%0d want %h/%b@%0d", i, b_data[i], b_last[i],
                         b_cyc[i], 32'h100 + i, (i == 15), b_cyc[0] + i);
            end
        end
        checks++;
        if (rd_cyc[0] != c0 || b_cyc[0] != c0 + 2) begin
            errors++;
            $display("FAIL full_latency got read@%0d beat@%0d want read@%0d beat@%0d",
                     rd_cyc[0], b_cyc[0], c0, c0 + 2);
        end
        checks++;
        if (at - c0 > 16 + 4) begin
            errors++;
            $display("FAIL full_done_latency got %0d want <= 20", at - c0);
        end
    endtask

    task automatic test_wrap();
        int c0, at;
        logic [3:0] exp_a [4];
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        reset_logs();
        strm.i_ready = 1'b1;
        do_start(4'd14, 5'd4, c0);
        wait_done(20, "wrap", at);
        checks++;
        if (bn != 4 || rd_n != 4) begin
            errors++;
            $display("FAIL wrap_counts got beats=%0d reads=%0d want 4/4", bn, rd_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr[i] !== exp_a[i] || b_data[i] !== 32'h100 + exp_a[i] || b_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat[%0d] got a=%0d d=%h l=%b want a=%0d d=%h l=%b", i, rd_addr[i],
                         b_data[i], b_last[i], exp_a[i], 32'h100 + exp_a[i], (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        int c0, k;
        bit seen;
        logic [5:0] pat;
        pat = 6'b101001;
        reset_logs();
        strm.i_ready = 1'b1;
        do_start(4'd0, 5'd6, c0);
        seen = 1'b0;
        k = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            strm.i_ready = pat[k % 6];
            k++;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        strm.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || bn != 6 || done_n != 1) begin
            errors++;
            $display("FAIL bp_counts got done=%b beats=%0d dones=%0d want 1/6/1", seen, bn, done_n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (b_data[i] !== 32'h100 + i || b_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL bp_beat[%0d] got %h/%b want %h/%b", i, b_data[i], b_last[i],
                         32'h100 + i, (i == 5));
            end
        end
    endtask

    task automatic test_stall();
        int c0, at;
        reset_logs();
        strm.i_ready = 1'b0;
        do_start(4'd0, 5'd8, c0);
        repeat (10) @(negedge clk);
        checks++;
        if (rd_n != 3 || bn != 0 || !strm.o_valid) begin
            errors++;
            $display("FAIL stall_reads got reads=%0d beats=%0d valid=%b want 3/0/1", rd_n, bn, strm.o_valid);
        end
        @(posedge clk); #1;
        strm.i_ready = 1'b1;
        wait_done(20, "stall", at);
        checks++;
        if (bn != 8 || rd_n != 8) begin
            errors++;
            $display("FAIL stall_counts got beats=%0d reads=%0d want 8/8", bn, rd_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (b_data[i] !== 32'h100 + i || b_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL stall_beat[%0d] got %h/%b want %h/%b", i, b_data[i], b_last[i],
                         32'h100 + i, (i == 7));
            end
        end
    endtask

    task automatic test_len0_and_ignore();
        int c0, c1, at;
        logic d0, d1;
        reset_logs();
        strm.i_ready = 1'b1;
        do_start(4'd5, 5'd0, c0);
        @(negedge clk); d0 = done;
        @(negedge clk); d1 = done;
        repeat (3) @(negedge clk);
        checks++;
        if (d0 !== 1'b1 || d1 !== 1'b0 || rd_n != 0 || valid_n != 0 || done_n != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0 got done=%b,%b reads=%0d valids=%0d dones=%0d want 1,0 0 0 1",
                     d0, d1, rd_n, valid_n, done_n);
        end
        reset_logs();
        do_start(4'd0, 5'd8, c0);
        do_start(4'd4, 5'd3, c1);
        wait_done(30, "ignore", at);
        checks++;
        if (bn != 8 || rd_n != 8 || done_n != 1) begin
            errors++;
            $display("FAIL ignore_counts got beats=%0d reads=%0d dones=%0d want 8/8/1", bn, rd_n, done_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (b_data[i] !== 32'h100 + i || b_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL ignore_beat[%0d] got %h/%b want %h/%b", i, b_data[i], b_last[i],
                         32'h100 + i, (i == 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0, at;
        logic [41:0] obs;
        reset_logs();
        strm.i_ready = 1'b1;
        do_start(4'd0, 5'd10, c0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bn >= 3) break;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        obs = {cenb, wenb, addr, strm.o_valid, strm.o_last, busy, done, strm.o_data};
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL midreset_outputs got %h want %h", obs,
                     {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        end
        reset_logs();
        repeat (5) @(negedge clk);
        checks++;
        if (done_n != 0 || bn != 0 || rd_n != 0) begin
            errors++;
            $display("FAIL midreset_quiet got dones=%0d beats=%0d reads=%0d want 0/0/0", done_n, bn, rd_n);
        end
        do_start(4'd2, 5'd2, c0);
        wait_done(15, "after_reset", at);
        checks++;
        if (bn != 2 || b_data[0] !== 32'h102 || b_last[0] !== 1'b0 ||
            b_data[1] !== 32'h103 || b_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got n=%0d %h/%b %h/%b want 2 00000102/0 00000103/1",
                     bn, b_data[0], b_last[0], b_data[1], b_last[1]);
        end
    endtask

    initial begin
        strm.i_ready = 1'b1;
        reset_logs();
        test_reset();
        test_full_depth();
        test_wrap();
        test_backpressure();
        test_stall();
        test_len0_and_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
